// File: rtl/writeback_queue_if.sv
// Writeback queue bus: execute-side enqueue, regfile write ports, pending lookup.
// Shared by writeback_queue (slave) and its producer/consumer (master).
interface writeback_queue_if #(
   parameter int SIZE       = 32,
   parameter int REG_NUM    = 8,
   parameter int DEPTH      = 8,
   parameter int READ_PORTS = 2
);
   localparam int RW = $clog2(REG_NUM);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [1:0]                 enq_valid;
   logic [1:0][RW-1:0]         enq_reg;
   logic [1:0][SIZE-1:0]       enq_data;
   logic                       enq_ready;
   logic                       wb_hold;
   logic [1:0]                 RegWrite;
   logic [1:0][RW-1:0]         write_reg;
   logic [1:0][SIZE-1:0]       write_data;
   logic [READ_PORTS-1:0][RW-1:0] query_reg;
   logic [READ_PORTS-1:0]      query_pending;
   logic [CW-1:0]              count;
   logic                       empty;

   modport master (
      output enq_valid, enq_reg, enq_data, wb_hold, query_reg,
      input  enq_ready, RegWrite, write_reg, write_data,
      input  query_pending, count, empty
   );

   modport slave (
      input  enq_valid, enq_reg, enq_data, wb_hold, query_reg,
      output enq_ready, RegWrite, write_reg, write_data,
      output query_pending, count, empty
   );
endinterface

// File: rtl/writeback_queue.sv
// In-order two-wide writeback queue feeding the register file write ports.
// Optional macro WBQ_COALESCE_EN: drop the older write when both target one reg.
module writeback_queue #(
   parameter int SIZE       = 32,
   parameter int REG_NUM    = 8,
   parameter int DEPTH      = 8,
   parameter int READ_PORTS = 2
) (
   input  logic              clk,
   input  logic              rst,
   writeback_queue_if.slave  bus
);
   localparam int RW = $clog2(REG_NUM);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef logic [PW-1:0] ptr_t;

   logic [RW-1:0]        slot_reg_q  [DEPTH];
   logic [RW-1:0]        slot_reg_d  [DEPTH];
   logic [SIZE-1:0]      slot_data_q [DEPTH];
   logic [SIZE-1:0]      slot_data_d [DEPTH];

   ptr_t                 head_q, head_d;
   ptr_t                 tail_q, tail_d;
   logic [CW-1:0]        count_q, count_d;
   logic [1:0]           reg_write_q, reg_write_d;
   logic [1:0][RW-1:0]   write_reg_q, write_reg_d;
   logic [1:0][SIZE-1:0] write_data_q, write_data_d;

   logic                 enq_ok;
   logic [1:0]           nenq;
   logic [1:0]           ndeq;
   ptr_t                 head_p1;
   ptr_t                 tail_p1;
   logic [DEPTH-1:0]     occ;
   logic [READ_PORTS-1:0] pending;

   assign head_p1 = head_q + ptr_t'(1);
   assign tail_p1 = tail_q + ptr_t'(1);

   // Room for a full two-lane push, judged on registered occupancy only.
   assign enq_ok = (count_q <= CW'(DEPTH - 2));

   // Per-cycle admission and retirement counts.
   always_comb begin
      nenq = 2'd0;
      if (enq_ok) begin
         nenq = {1'b0, bus.enq_valid[0]} + {1'b0, bus.enq_valid[1]};
      end
      ndeq = 2'd0;
      if (!bus.wb_hold) begin
         if (count_q >= CW'(2)) begin
            ndeq = 2'd2;
         end else begin
            ndeq = count_q[1:0];
         end
      end
   end

   // Compact valid lanes into consecutive slots from tail, lane 0 first.
   always_comb begin
      slot_reg_d  = slot_reg_q;
      slot_data_d = slot_data_q;
      if (enq_ok) begin
         unique case (bus.enq_valid)
            2'b01: begin
               slot_reg_d[tail_q]  = bus.enq_reg[0];
               slot_data_d[tail_q] = bus.enq_data[0];
            end
            2'b10: begin
               slot_reg_d[tail_q]  = bus.enq_reg[1];
               slot_data_d[tail_q] = bus.enq_data[1];
            end
            2'b11: begin
               slot_reg_d[tail_q]   = bus.enq_reg[0];
               slot_data_d[tail_q]  = bus.enq_data[0];
               slot_reg_d[tail_p1]  = bus.enq_reg[1];
               slot_data_d[tail_p1] = bus.enq_data[1];
            end
            default: begin
            end
         endcase
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap on their own width.
   always_comb begin
      tail_d  = tail_q + ptr_t'(nenq);
      head_d  = head_q + ptr_t'(ndeq);
      count_d = count_q + CW'(nenq) - CW'(ndeq);
   end

   // Next write-port image: oldest entry on port 0, next on port 1.
   always_comb begin
      reg_write_d  = 2'b00;
      write_reg_d  = '0;
      write_data_d = '0;
      if (ndeq != 2'd0) begin
         reg_write_d[0]  = 1'b1;
         write_reg_d[0]  = slot_reg_q[head_q];
         write_data_d[0] = slot_data_q[head_q];
      end
      if (ndeq == 2'd2) begin
         reg_write_d[1]  = 1'b1;
         write_reg_d[1]  = slot_reg_q[head_p1];
         write_data_d[1] = slot_data_q[head_p1];
`ifdef WBQ_COALESCE_EN
         if (slot_reg_q[head_q] == slot_reg_q[head_p1]) begin
            reg_write_d[0]  = 1'b0;
            write_reg_d[0]  = '0;
            write_data_d[0] = '0;
         end
`else
`endif
      end
   end

   // Mark slots lying in the live window head .. head+count-1.
   always_comb begin
      occ = '0;
      for (int j = 0; j < DEPTH; j++) begin
         occ[j] = ({1'b0, ptr_t'(ptr_t'(j) - head_q)} < count_q);
      end
   end

   // Pending lookup over live slots and the write ports now driven.
   always_comb begin
      pending = '0;
      for (int i = 0; i < READ_PORTS; i++) begin
         for (int j = 0; j < DEPTH; j++) begin
            if (occ[j] && (slot_reg_q[j] == bus.query_reg[i])) begin
               pending[i] = 1'b1;
            end
         end
         for (int p = 0; p < 2; p++) begin
            if (reg_write_q[p] && (write_reg_q[p] == bus.query_reg[i])) begin
               pending[i] = 1'b1;
            end
         end
      end
   end

   // Control state and registered write port; reset drops in-flight entries.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         reg_write_q  <= 2'b00;
         write_reg_q  <= '0;
         write_data_q <= '0;
      end else begin
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         reg_write_q  <= reg_write_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
      end
   end

   // Slot storage; contents are meaningless outside the live window.
   always_ff @(posedge clk) begin
      for (int j = 0; j < DEPTH; j++) begin
         slot_reg_q[j]  <= slot_reg_d[j];
         slot_data_q[j] <= slot_data_d[j];
      end
   end

   assign bus.enq_ready     = enq_ok;
   assign bus.RegWrite      = reg_write_q;
   assign bus.write_reg     = write_reg_q;
   assign bus.write_data    = write_data_q;
   assign bus.query_pending = pending;
   assign bus.count         = count_q;
   assign bus.empty         = (count_q == '0);
endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: ordering, occupancy, hold, pending.
// Entries are queued when admitted and popped as the write ports fire.
module tb_writeback_queue;
   localparam int SIZE       = 32;
   localparam int REG_NUM    = 8;
   localparam int DEPTH      = 8;
   localparam int READ_PORTS = 2;

   typedef struct packed {
      logic [2:0]  r;
      logic [31:0] d;
   } ent_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   writeback_queue_if #(
      .SIZE(SIZE), .REG_NUM(REG_NUM), .DEPTH(DEPTH), .READ_PORTS(READ_PORTS)
   ) bus ();

   writeback_queue #(
      .SIZE(SIZE), .REG_NUM(REG_NUM), .DEPTH(DEPTH), .READ_PORTS(READ_PORTS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   ent_t        sb[$];
   ent_t        ea;
   ent_t        eb;
   logic [31:0] rf [REG_NUM];
   int          total = 0;
   int          bad = 0;
   int          m_count = 0;
   bit          mon_en = 1'b0;

   // Register file model plus scoreboard check on each negedge write.
   always @(negedge clk) begin
      if (mon_en) begin
`ifdef WBQ_COALESCE_EN
         if (bus.RegWrite === 2'b10 && sb.size() >= 2) begin
            total++;
            ea = sb.pop_front();
            eb = sb.pop_front();
            if (ea.r !== eb.r || bus.write_reg[1] !== eb.r ||
                bus.write_data[1] !== eb.d) begin
               bad++;
               $display("FAIL wb_coalesce got r=%0d d=%h exp r=%0d d=%h",
                        bus.write_reg[1], bus.write_data[1], eb.r, eb.d);
            end
            rf[bus.write_reg[1]] = bus.write_data[1];
         end else begin
`else
         begin
`endif
            for (int p = 0; p < 2; p++) begin
               if (bus.RegWrite[p] === 1'b1) begin
                  total++;
                  if (sb.size() == 0) begin
                     bad++;
                     $display("FAIL wb_extra port=%0d got r=%0d d=%h exp none",
                              p, bus.write_reg[p], bus.write_data[p]);
                  end else begin
                     ea = sb.pop_front();
                     if (bus.write_reg[p] !== ea.r ||
                         bus.write_data[p] !== ea.d) begin
                        bad++;
                        $display("FAIL wb_order port=%0d got r=%0d d=%h exp r=%0d d=%h",
                                 p, bus.write_reg[p], bus.write_data[p],
                                 ea.r, ea.d);
                     end
                  end
                  rf[bus.write_reg[p]] = bus.write_data[p];
               end
            end
         end
         if (bus.RegWrite === 2'b00) begin
            total++;
            if (bus.write_reg !== '0 || bus.write_data !== '0) begin
               bad++;
               $display("FAIL wb_idle_zero got r=%h d=%h exp 0",
                        bus.write_reg, bus.write_data);
            end
         end
      end
   end

   // One clock of stimulus with the bench's own occupancy model.
   task automatic cyc(input logic [1:0] v,
                      input logic [2:0] r0, input logic [31:0] d0,
                      input logic [2:0] r1, input logic [31:0] d1,
                      input logic h);
      int ne;
      int nd;
      bit acc;
      bus.enq_valid   = v;
      bus.enq_reg[0]  = r0;
      bus.enq_data[0] = d0;
      bus.enq_reg[1]  = r1;
      bus.enq_data[1] = d1;
      bus.wb_hold     = h;
      acc = (m_count <= DEPTH - 2) && (rst == 1'b0);
      ne  = acc ? (int'(v[0]) + int'(v[1])) : 0;
      nd  = (rst || h) ? 0 : ((m_count < 2) ? m_count : 2);
      if (acc && v[0]) sb.push_back({r0, d0});
      if (acc && v[1]) sb.push_back({r1, d1});
      @(posedge clk);
      m_count = rst ? 0 : (m_count + ne - nd);
      if (rst) sb.delete();
      #1;
      bus.enq_valid = 2'b00;
   endtask

   task automatic idle(input logic h);
      cyc(2'b00, 3'd0, 32'h0, 3'd0, 32'h0, h);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle(1'b0);
      idle(1'b0);
      mon_en = 1'b1;
      total++;
      if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin
         bad++;
         $display("FAIL reset_count got=%0d empty=%b exp 0/1", bus.count, bus.empty);
      end
      total++;
      if (bus.enq_ready !== 1'b1 || bus.RegWrite !== 2'b00) begin
         bad++;
         $display("FAIL reset_ports got rdy=%b we=%b exp 1/00",
                  bus.enq_ready, bus.RegWrite);
      end
      rst = 1'b0;
   endtask

   task automatic test_reset_mid;
      cyc(2'b11, 3'd1, 32'hA1, 3'd2, 32'hA2, 1'b1);
      cyc(2'b11, 3'd3, 32'hA3, 3'd4, 32'hA4, 1'b1);
      cyc(2'b01, 3'd5, 32'hA5, 3'd6, 32'hA6, 1'b1);
      total++;
      if (bus.count !== 4'd5) begin
         bad++;
         $display("FAIL mid_count got=%0d exp=5", bus.count);
      end
      rst = 1'b1;
      cyc(2'b11, 3'd7, 32'hA7, 3'd7, 32'hA8, 1'b0);
      total++;
      if (bus.count !== 4'd0 || bus.RegWrite !== 2'b00 || bus.empty !== 1'b1) begin
         bad++;
         $display("FAIL mid_reset got cnt=%0d we=%b exp 0/00",
                  bus.count, bus.RegWrite);
      end
      rst = 1'b0;
   endtask

   task automatic test_pair;
      cyc(2'b11, 3'd3, 32'h11, 3'd5, 32'h22, 1'b0);
      total++;
      if (bus.count !== 4'd2 || bus.RegWrite !== 2'b00) begin
         bad++;
         $display("FAIL pair_enq got cnt=%0d we=%b exp 2/00",
                  bus.count, bus.RegWrite);
      end
      idle(1'b0);
      total++;
      if (bus.RegWrite !== 2'b11 || bus.write_reg[0] !== 3'd3 ||
          bus.write_reg[1] !== 3'd5) begin
         bad++;
         $display("FAIL pair_we got we=%b r0=%0d r1=%0d exp 11/3/5",
                  bus.RegWrite, bus.write_reg[0], bus.write_reg[1]);
      end
      total++;
      if (bus.write_data[0] !== 32'h11 || bus.write_data[1] !== 32'h22 ||
          bus.count !== 4'd0) begin
         bad++;
         $display("FAIL pair_data got d0=%h d1=%h cnt=%0d exp 11/22/0",
                  bus.write_data[0], bus.write_data[1], bus.count);
      end
   endtask

   task automatic test_single;
      cyc(2'b10, 3'd0, 32'h0, 3'd6, 32'hAB, 1'b0);
      total++;
      if (bus.count !== 4'd1) begin
         bad++;
         $display("FAIL single_cnt got=%0d exp=1", bus.count);
      end
      idle(1'b0);
      total++;
      if (bus.RegWrite !== 2'b01 || bus.write_reg[0] !== 3'd6 ||
          bus.write_data[0] !== 32'hAB) begin
         bad++;
         $display("FAIL single_we got we=%b r=%0d d=%h exp 01/6/ab",
                  bus.RegWrite, bus.write_reg[0], bus.write_data[0]);
      end
      idle(1'b0);
      total++;
      if (bus.RegWrite !== 2'b00 || bus.empty !== 1'b1) begin
         bad++;
         $display("FAIL single_idle got we=%b empty=%b exp 00/1",
                  bus.RegWrite, bus.empty);
      end
   endtask

   task automatic test_hold_wrap;
      for (int k = 0; k < 3; k++) begin
         cyc(2'b11, 3'(2 * k), 32'h100 + 32'(2 * k),
             3'(2 * k + 1), 32'h101 + 32'(2 * k), 1'b1);
      end
      total++;
      if (bus.count !== 4'd6 || bus.enq_ready !== 1'b1) begin
         bad++;
         $display("FAIL hold_six got cnt=%0d rdy=%b exp 6/1",
                  bus.count, bus.enq_ready);
      end
      cyc(2'b01, 3'd7, 32'h1FF, 3'd0, 32'h0, 1'b1);
      total++;
      if (bus.count !== 4'd7 || bus.enq_ready !== 1'b0) begin
         bad++;
         $display("FAIL hold_seven got cnt=%0d rdy=%b exp 7/0",
                  bus.count, bus.enq_ready);
      end
      cyc(2'b11, 3'd1, 32'hDEAD, 3'd2, 32'hBEEF, 1'b1);
      total++;
      if (bus.count !== 4'd7 || bus.RegWrite !== 2'b00) begin
         bad++;
         $display("FAIL hold_ignore got cnt=%0d we=%b exp 7/00",
                  bus.count, bus.RegWrite);
      end
      idle(1'b0);
      total++;
      if (bus.count !== 4'd5 || bus.RegWrite !== 2'b11) begin
         bad++;
         $display("FAIL drain_first got cnt=%0d we=%b exp 5/11",
                  bus.count, bus.RegWrite);
      end
      idle(1'b0);
      idle(1'b0);
      idle(1'b0);
      total++;
      if (bus.count !== 4'd0 || bus.RegWrite !== 2'b01) begin
         bad++;
         $display("FAIL drain_last got cnt=%0d we=%b exp 0/01",
                  bus.count, bus.RegWrite);
      end
      idle(1'b0);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain_sb got=%0d left exp=0", sb.size());
      end
   endtask

   task automatic test_full;
      for (int k = 0; k < 4; k++) begin
         cyc(2'b11, 3'(k), 32'h200 + 32'(k),
             3'(7 - k), 32'h300 + 32'(k), 1'b1);
      end
      total++;
      if (bus.count !== 4'd8 || bus.enq_ready !== 1'b0 || bus.empty !== 1'b0) begin
         bad++;
         $display("FAIL full got cnt=%0d rdy=%b exp 8/0",
                  bus.count, bus.enq_ready);
      end
      for (int k = 0; k < 5; k++) idle(1'b0);
      total++;
      if (bus.count !== 4'd0 || bus.RegWrite !== 2'b00 || sb.size() != 0) begin
         bad++;
         $display("FAIL full_drain got cnt=%0d we=%b sb=%0d exp 0/00/0",
                  bus.count, bus.RegWrite, sb.size());
      end
   endtask

   task automatic test_back_to_back;
      for (int k = 0; k < 8; k++) begin
         cyc(2'b11, 3'(k), 32'h400 + 32'(k),
             3'(k + 3), 32'h500 + 32'(k), 1'b0);
         total++;
         if (bus.count !== 4'd2 || bus.enq_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_steady k=%0d got cnt=%0d rdy=%b exp 2/1",
                     k, bus.count, bus.enq_ready);
         end
      end
      idle(1'b0);
      idle(1'b0);
      total++;
      if (bus.empty !== 1'b1 || sb.size() != 0 || m_count != 0) begin
         bad++;
         $display("FAIL b2b_drain got empty=%b sb=%0d exp 1/0",
                  bus.empty, sb.size());
      end
   endtask

   task automatic test_same_dest;
      cyc(2'b11, 3'd2, 32'h1, 3'd2, 32'h2, 1'b0);
      idle(1'b0);
      total++;
`ifdef WBQ_COALESCE_EN
      if (bus.RegWrite !== 2'b10) begin
         bad++;
         $display("FAIL same_we got=%b exp=10", bus.RegWrite);
      end
`else
      if (bus.RegWrite !== 2'b11) begin
         bad++;
         $display("FAIL same_we got=%b exp=11", bus.RegWrite);
      end
`endif
      total++;
      if (bus.write_reg[1] !== 3'd2 || bus.write_data[1] !== 32'h2) begin
         bad++;
         $display("FAIL same_port1 got r=%0d d=%h exp 2/2",
                  bus.write_reg[1], bus.write_data[1]);
      end
      idle(1'b0);
      total++;
      if (rf[2] !== 32'h2) begin
         bad++;
         $display("FAIL same_rf got=%h exp=2", rf[2]);
      end
   endtask

   task automatic test_pending;
      bus.query_reg[0] = 3'd4;
      bus.query_reg[1] = 3'd1;
      #1;
      total++;
      if (bus.query_pending !== 2'b00) begin
         bad++;
         $display("FAIL pend_before got=%b exp=00", bus.query_pending);
      end
      cyc(2'b01, 3'd4, 32'h44, 3'd0, 32'h0, 1'b0);
      total++;
      if (bus.query_pending !== 2'b01) begin
         bad++;
         $display("FAIL pend_queued got=%b exp=01", bus.query_pending);
      end
      idle(1'b0);
      total++;
      if (bus.query_pending !== 2'b01 || bus.RegWrite !== 2'b01) begin
         bad++;
         $display("FAIL pend_port got=%b we=%b exp 01/01",
                  bus.query_pending, bus.RegWrite);
      end
      idle(1'b0);
      total++;
      if (bus.query_pending !== 2'b00 || rf[4] !== 32'h44) begin
         bad++;
         $display("FAIL pend_after got=%b rf=%h exp 00/44",
                  bus.query_pending, rf[4]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      rst           = 1'b1;
      bus.enq_valid = 2'b00;
      bus.enq_reg   = '0;
      bus.enq_data  = '0;
      bus.wb_hold   = 1'b0;
      bus.query_reg = '0;
      for (int i = 0; i < REG_NUM; i++) rf[i] = 32'h0;
      test_reset();
      test_reset_mid();
      test_pair();
      test_single();
      test_hold_wrap();
      test_full();
      test_back_to_back();
      test_same_dest();
      test_pending();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
